// File: rtl/multicycle_core.sv
// multicycle_core: RV32I-subset core, FETCH/DECODE/EXECUTE/MEM/WB/HALT sequencer.
// One unified memory port with a req/ready handshake tolerating any number of wait states.
module multicycle_core #(
    parameter int          XLEN      = 32,
    parameter int          REG_COUNT = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic [XLEN-1:0] pc,
    output logic            retired,
    output logic            halted,
    output logic            trap,
    input  logic [4:0]      dbg_reg_addr,
    output logic [XLEN-1:0] dbg_reg_data
);
    generate
        if (XLEN != 32) begin : g_bad_xlen
            $error("multicycle_core: XLEN must be 32");
        end
        if (REG_COUNT != 32 && REG_COUNT != 16) begin : g_bad_regs
            $error("multicycle_core: REG_COUNT must be 16 or 32");
        end
    endgenerate

    localparam int RW = $clog2(REG_COUNT);
    localparam logic [6:0] OP_IMM = 7'b0010011, OP = 7'b0110011, LUI = 7'b0110111,
                           JAL = 7'b1101111, BRANCH = 7'b1100011, LOAD = 7'b0000011,
                           STORE = 7'b0100011, SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, HALT} state_t;

    state_t          state, state_nx;
    logic [XLEN-1:0] regs [REG_COUNT];
    logic [31:0]     instr, op_a, op_b, imm, result, next_pc, addr;
    logic [31:0]     imm_d, alu, alu_b, tgt, ea, lane, load_val;
    logic [6:0]      opcode;
    logic [4:0]      rd, rs1, rs2, shamt;
    logic [2:0]      f3;
    logic            legal, bad_idx, use_rd, use_rs1, use_rs2;
    logic            taken, misal, is_store, wr_en, set_trap, set_halt;

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign f3       = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign is_store = (opcode == STORE);
    assign wr_en    = opcode inside {OP_IMM, OP, LUI, JAL, LOAD};

    // Out-of-range indices (RV32E) and x0 read as zero.
    function automatic logic [XLEN-1:0] rd_reg(input logic [4:0] idx);
        if (idx == 5'd0 || (REG_COUNT == 16 && idx[4])) return '0;
        return regs[idx[RW-1:0]];
    endfunction

    assign dbg_reg_data = rd_reg(dbg_reg_addr);

    always_comb begin
        legal = 1'b0; imm_d = '0; use_rd = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0;
        case (opcode)
            OP_IMM: begin legal = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1;
                          imm_d = {{20{instr[31]}}, instr[31:20]}; end
            OP:     begin legal = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            LUI:    begin legal = 1'b1; use_rd = 1'b1; imm_d = {instr[31:12], 12'b0}; end
            JAL:    begin legal = 1'b1; use_rd = 1'b1;
                          imm_d = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0}; end
            BRANCH: begin legal = !(f3 inside {3'd2, 3'd3}); use_rs1 = 1'b1; use_rs2 = 1'b1;
                          imm_d = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0}; end
            LOAD:   begin legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; use_rd = 1'b1; use_rs1 = 1'b1;
                          imm_d = {{20{instr[31]}}, instr[31:20]}; end
            STORE:  begin legal = f3 inside {3'd0, 3'd1, 3'd2}; use_rs1 = 1'b1; use_rs2 = 1'b1;
                          imm_d = {{20{instr[31]}}, instr[31:25], instr[11:7]}; end
            SYSTEM: legal = (f3 == 3'd0);
            default: ;
        endcase
        bad_idx = (REG_COUNT == 16) &&
                  ((use_rd && rd[4]) || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4]));
    end

    always_comb begin
        alu_b = (opcode == OP) ? op_b : imm;
        shamt = alu_b[4:0];
        alu   = '0;
        case (f3)
            3'd0: alu = (opcode == OP && instr[30]) ? op_a - alu_b : op_a + alu_b;
            3'd1: alu = op_a << shamt;
            3'd2: alu = {31'b0, $signed(op_a) < $signed(alu_b)};
            3'd3: alu = {31'b0, op_a < alu_b};
            3'd4: alu = op_a ^ alu_b;
            3'd5: if (instr[30]) alu = $signed(op_a) >>> shamt;
                  else           alu = op_a >> shamt;
            3'd6: alu = op_a | alu_b;
            default: alu = op_a & alu_b;
        endcase
        case (f3)
            3'd0: taken = (op_a == op_b);
            3'd1: taken = (op_a != op_b);
            3'd4: taken = $signed(op_a) < $signed(op_b);
            3'd5: taken = $signed(op_a) >= $signed(op_b);
            3'd6: taken = op_a < op_b;
            default: taken = op_a >= op_b;
        endcase
        tgt = pc + imm;
        ea  = op_a + imm;
        case (f3[1:0])
            2'd1: misal = ea[0];
            2'd2: misal = (ea[1:0] != 2'b00);
            default: misal = 1'b0;
        endcase
    end

    // Lane-shifted read data; addr[1:0] is zero for LW so lane is the full word.
    always_comb begin
        lane = mem_rdata >> {addr[1:0], 3'b000};
        case (f3)
            3'd0: load_val = {{24{lane[7]}}, lane[7:0]};
            3'd1: load_val = {{16{lane[15]}}, lane[15:0]};
            3'd4: load_val = {24'b0, lane[7:0]};
            3'd5: load_val = {16'b0, lane[15:0]};
            default: load_val = lane;
        endcase
    end

    always_comb begin
        mem_req   = reset_n && (state == FETCH || state == MEM);
        mem_we    = (state == MEM) && is_store;
        mem_addr  = (state == MEM) ? {addr[31:2], 2'b00} : pc;
        mem_wstrb = '0;
        case (f3)
            3'd0:    mem_wdata = {4{op_b[7:0]}};
            3'd1:    mem_wdata = {2{op_b[15:0]}};
            default: mem_wdata = op_b;
        endcase
        if (mem_we) begin
            case (f3)
                3'd0:    mem_wstrb = 4'b0001 << addr[1:0];
                3'd1:    mem_wstrb = 4'b0011 << addr[1:0];
                default: mem_wstrb = 4'b1111;
            endcase
        end
        retired = (state == WB) || ((state == MEM) && is_store && mem_ready);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= FETCH;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state; set_trap = 1'b0; set_halt = 1'b0;
        case (state)
            FETCH:  if (mem_ready) state_nx = DECODE;
            DECODE: if (!legal || bad_idx) begin set_trap = 1'b1; state_nx = HALT; end
                    else state_nx = EXECUTE;
            EXECUTE: begin
                state_nx = WB;
                case (opcode)
                    SYSTEM:      begin set_halt = 1'b1; state_nx = HALT; end
                    LOAD, STORE: if (misal) begin set_trap = 1'b1; state_nx = HALT; end
                                 else state_nx = MEM;
                    BRANCH:      if (taken && tgt[1]) begin set_trap = 1'b1; state_nx = HALT; end
                    JAL:         if (tgt[1]) begin set_trap = 1'b1; state_nx = HALT; end
                    default: ;
                endcase
            end
            MEM:     if (mem_ready) state_nx = is_store ? FETCH : WB;
            WB:      state_nx = FETCH;
            default: state_nx = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC; instr <= '0; op_a <= '0; op_b <= '0; imm <= '0;
            result <= '0; next_pc <= '0; addr <= '0; halted <= 1'b0; trap <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else begin
            halted <= halted | set_trap | set_halt;
            trap   <= trap | set_trap;
            case (state)
                FETCH:   if (mem_ready) instr <= mem_rdata;
                DECODE:  begin op_a <= rd_reg(rs1); op_b <= rd_reg(rs2); imm <= imm_d; end
                EXECUTE: begin
                    result  <= (opcode == LUI) ? imm : (opcode == JAL) ? pc + 32'd4 : alu;
                    next_pc <= ((opcode == JAL) || (opcode == BRANCH && taken)) ? tgt : pc + 32'd4;
                    addr    <= ea;
                end
                MEM: if (mem_ready) begin
                    if (is_store) pc <= pc + 32'd4;
                    else          result <= load_val;
                end
                WB: begin
                    if (wr_en && rd != 5'd0) regs[rd[RW-1:0]] <= result;
                    pc <= next_pc;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: small programs in a word memory with optional wait states.
module tb_multicycle_core;
    logic        clk = 1'b0, reset_n = 1'b1;
    logic        mem_req, mem_we, mem_ready = 1'b0, retired, halted, trap;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, dbg_reg_data;
    logic [3:0]  mem_wstrb;
    logic [4:0]  dbg_reg_addr = 5'd0;

    int n_tests = 0, n_fail = 0;
    int wait_cnt = 0, cyc = 0, ret_n = 0, req_n = 0, st_n = 0, stall_n = 0, stab_err = 0;
    int ret_cyc [64];
    logic [31:0] mem [256];
    logic [31:0] st_addr [8], st_data [8];
    logic [3:0]  st_strb [8];
    bit          rnd_stall = 1'b0, force_stall = 1'b0, prev_stall = 1'b0;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_strb;
    logic        p_we;

    localparam logic [31:0] ECALL = 32'h0000_0073;

    multicycle_core dut (
        .clk(clk), .reset_n(reset_n), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc), .retired(retired),
        .halted(halted), .trap(trap), .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(dbg_reg_data)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(negedge clk) mem_ready = !force_stall && (wait_cnt == 0);

    // Memory model and bus monitor.
    always @(posedge clk) begin
        if (!reset_n) prev_stall = 1'b0;
        else begin
            cyc++;
            if (retired) begin
                if (ret_n < 64) ret_cyc[ret_n] = cyc;
                ret_n++;
            end
            if (prev_stall && mem_req &&
                (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata || mem_wstrb !== p_strb))
                stab_err++;
            prev_stall = mem_req && !mem_ready;
            p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata; p_strb = mem_wstrb;
            if (mem_req && mem_ready) begin
                req_n++;
                if (mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_wstrb[b]) mem[mem_addr[9:2]][b*8 +: 8] = mem_wdata[b*8 +: 8];
                    if (st_n < 8) begin
                        st_addr[st_n] = mem_addr; st_data[st_n] = mem_wdata; st_strb[st_n] = mem_wstrb;
                    end
                    st_n++;
                end
                wait_cnt = rnd_stall ? int'($urandom_range(0, 5)) : 0;
            end else if (mem_req) begin
                stall_n++;
                if (wait_cnt > 0) wait_cnt--;
            end
        end
    end

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [2:0] f3, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return enc_i(7'h13, rd, 3'd0, rs1, imm);
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    task automatic clear_mem;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    task automatic start(input bit stall);
        reset_n = 1'b0; rnd_stall = stall; force_stall = 1'b0;
        wait_cnt = stall ? 2 : 0;
        cyc = 0; ret_n = 0; req_n = 0; st_n = 0; stall_n = 0; stab_err = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic run_halt(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (halted) begin ok = 1'b1; break; end
        end
    endtask

    task automatic rd_dbg(input logic [4:0] a, output logic [31:0] v);
        dbg_reg_addr = a; #1; v = dbg_reg_data;
    endtask

    task automatic load_alu;
        clear_mem();
        mem[0] = addi(5'd1, 5'd0, 12'hffb);
        mem[1] = addi(5'd2, 5'd0, 12'h003);
        mem[2] = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3);
        mem[3] = enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd4);
        mem[4] = ECALL;
    endtask

    task automatic load_mem;
        clear_mem();
        mem[0] = {20'h87654, 5'd8, 7'h37};
        mem[1] = addi(5'd8, 5'd8, 12'h321);
        mem[2] = addi(5'd9, 5'd0, 12'h100);
        mem[3] = enc_s(3'd2, 5'd8, 5'd9, 12'd0);
        mem[4] = enc_i(7'h03, 5'd5, 3'd0, 5'd9, 12'd1);
        mem[5] = enc_i(7'h03, 5'd6, 3'd4, 5'd9, 12'd3);
        mem[6] = enc_i(7'h03, 5'd7, 3'd1, 5'd9, 12'd2);
        mem[7] = enc_s(3'd0, 5'd8, 5'd9, 12'd2);
        mem[8] = ECALL;
    endtask

    task automatic load_br;
        clear_mem();
        mem[0] = addi(5'd10, 5'd0, 12'd3);
        mem[1] = addi(5'd1, 5'd1, 12'd1);
        mem[2] = enc_b(3'd1, 5'd1, 5'd10, 13'h1ffc);
        mem[3] = enc_j(5'd11, 21'd8);
        mem[4] = addi(5'd12, 5'd0, 12'd99);
        mem[5] = ECALL;
    endtask

    task automatic test_reset;
        bit ok; logic [31:0] v;
        clear_mem(); mem[0] = ECALL;
        reset_n = 1'b0;
        @(negedge clk); #1;
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        n_tests++; if (mem_we !== 1'b0 || mem_wstrb !== 4'h0) begin n_fail++; $display("FAIL reset_we_strb got %b/%h want 0/0", mem_we, mem_wstrb); end
        n_tests++; if (retired !== 1'b0 || halted !== 1'b0 || trap !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %b%b%b want 000", retired, halted, trap); end
        n_tests++; if (pc !== 32'h0 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h/%h want 0/0", pc, mem_addr); end
        rd_dbg(5'd1, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_reg got %h want 0", v); end
        @(negedge clk); reset_n = 1'b1; #1;
        n_tests++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL first_fetch got req=%b we=%b want 1/0", mem_req, mem_we); end
        run_halt(50, ok);
    endtask

    task automatic test_alu;
        bit ok; logic [31:0] v;
        load_alu(); start(1'b0); run_halt(200, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL alu_timeout halted=%b want 1", halted); end
        rd_dbg(5'd3, v);
        n_tests++; if (v !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL alu_sub got %h want fffffff8", v); end
        rd_dbg(5'd4, v);
        n_tests++; if (v !== 32'h1) begin n_fail++; $display("FAIL alu_slt got %h want 1", v); end
        rd_dbg(5'd1, v);
        n_tests++; if (v !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL alu_addi_neg got %h want fffffffb", v); end
        n_tests++; if (ret_n !== 4) begin n_fail++; $display("FAIL alu_retired got %0d want 4", ret_n); end
        n_tests++; if (ret_cyc[1] - ret_cyc[0] !== 4 || ret_cyc[3] - ret_cyc[2] !== 4) begin n_fail++; $display("FAIL alu_latency got %0d/%0d want 4/4", ret_cyc[1] - ret_cyc[0], ret_cyc[3] - ret_cyc[2]); end
        n_tests++; if (trap !== 1'b0 || pc !== 32'd16) begin n_fail++; $display("FAIL ecall_state got trap=%b pc=%h want 0/10", trap, pc); end
        repeat (10) @(negedge clk);
        n_tests++; if (req_n !== 5 || mem_req !== 1'b0) begin n_fail++; $display("FAIL halt_quiet got reqs=%0d req=%b want 5/0", req_n, mem_req); end
    endtask

    task automatic check_mem_prog(input bit stall);
        bit ok; logic [31:0] v;
        load_mem(); start(stall); run_halt(600, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL mem_timeout stall=%b halted=%b want 1", stall, halted); end
        rd_dbg(5'd5, v);
        n_tests++; if (v !== 32'h0000_0043) begin n_fail++; $display("FAIL lb got %h want 00000043", v); end
        rd_dbg(5'd6, v);
        n_tests++; if (v !== 32'h0000_0087) begin n_fail++; $display("FAIL lbu got %h want 00000087", v); end
        rd_dbg(5'd7, v);
        n_tests++; if (v !== 32'hFFFF_8765) begin n_fail++; $display("FAIL lh got %h want ffff8765", v); end
        n_tests++; if (st_n !== 2 || st_strb[0] !== 4'b1111 || st_data[0] !== 32'h8765_4321 || st_addr[0] !== 32'h100) begin n_fail++; $display("FAIL sw_bus got n=%0d strb=%b data=%h addr=%h want 2/1111/87654321/100", st_n, st_strb[0], st_data[0], st_addr[0]); end
        n_tests++; if (st_strb[1] !== 4'b0100 || st_data[1][23:16] !== 8'h21 || st_addr[1] !== 32'h100) begin n_fail++; $display("FAIL sb_bus got strb=%b byte2=%h addr=%h want 0100/21/100", st_strb[1], st_data[1][23:16], st_addr[1]); end
        n_tests++; if (mem[64] !== 32'h8721_4321) begin n_fail++; $display("FAIL sb_mem got %h want 87214321", mem[64]); end
        n_tests++; if (pc !== 32'd32 || ret_n !== 8) begin n_fail++; $display("FAIL mem_end got pc=%h ret=%0d want 20/8", pc, ret_n); end
        n_tests++; if (stab_err !== 0) begin n_fail++; $display("FAIL mem_stable got %0d want 0", stab_err); end
    endtask

    task automatic test_mem;
        check_mem_prog(1'b0);
        n_tests++; if (ret_cyc[3] - ret_cyc[2] !== 4 || ret_cyc[4] - ret_cyc[3] !== 5) begin n_fail++; $display("FAIL ldst_latency got sw=%0d lb=%0d want 4/5", ret_cyc[3] - ret_cyc[2], ret_cyc[4] - ret_cyc[3]); end
    endtask

    task automatic check_br_prog(input bit stall);
        bit ok; logic [31:0] v;
        load_br(); start(stall); run_halt(600, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL br_timeout stall=%b halted=%b want 1", stall, halted); end
        rd_dbg(5'd1, v);
        n_tests++; if (v !== 32'd3) begin n_fail++; $display("FAIL bne_loop got %h want 3", v); end
        rd_dbg(5'd11, v);
        n_tests++; if (v !== 32'd16) begin n_fail++; $display("FAIL jal_link got %h want 10", v); end
        rd_dbg(5'd12, v);
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL jal_skip got %h want 0", v); end
        n_tests++; if (ret_n !== 8 || pc !== 32'd20) begin n_fail++; $display("FAIL br_end got ret=%0d pc=%h want 8/14", ret_n, pc); end
        n_tests++; if (stab_err !== 0) begin n_fail++; $display("FAIL br_stable got %0d want 0", stab_err); end
    endtask

    task automatic test_branch;
        check_br_prog(1'b0);
    endtask

    task automatic test_stall;
        int s;
        check_mem_prog(1'b1);
        s = stall_n;
        check_br_prog(1'b1);
        n_tests++; if (s + stall_n == 0) begin n_fail++; $display("FAIL stall_seen got %0d want >0", s + stall_n); end
    endtask

    task automatic test_trap;
        bit ok; logic [31:0] v;
        clear_mem();
        mem[0] = addi(5'd9, 5'd0, 12'h102);
        mem[1] = addi(5'd5, 5'd0, 12'd55);
        mem[2] = enc_i(7'h03, 5'd5, 3'd2, 5'd9, 12'd0);
        mem[3] = ECALL;
        start(1'b0); run_halt(200, ok);
        n_tests++; if (!ok || trap !== 1'b1) begin n_fail++; $display("FAIL lw_misal_trap got halted=%b trap=%b want 1/1", halted, trap); end
        rd_dbg(5'd5, v);
        n_tests++; if (v !== 32'd55) begin n_fail++; $display("FAIL lw_misal_rd got %h want 37", v); end
        repeat (5) @(negedge clk);
        n_tests++; if (req_n !== 3 || ret_n !== 2 || pc !== 32'd8) begin n_fail++; $display("FAIL lw_misal_bus got reqs=%0d ret=%0d pc=%h want 3/2/8", req_n, ret_n, pc); end
    endtask

    task automatic test_illegal;
        bit ok;
        clear_mem(); mem[0] = enc_b(3'd0, 5'd0, 5'd0, 13'd6);
        start(1'b0); run_halt(100, ok);
        n_tests++; if (!ok || trap !== 1'b1 || ret_n !== 0 || pc !== 32'd0) begin n_fail++; $display("FAIL br_misal got h=%b t=%b ret=%0d pc=%h want 1/1/0/0", halted, trap, ret_n, pc); end
        clear_mem(); mem[0] = 32'hFFFF_FFFF;
        start(1'b0); run_halt(100, ok);
        n_tests++; if (!ok || trap !== 1'b1 || ret_n !== 0) begin n_fail++; $display("FAIL bad_opcode got h=%b t=%b ret=%0d want 1/1/0", halted, trap, ret_n); end
    endtask

    task automatic test_x0;
        bit ok; logic [31:0] v;
        clear_mem();
        mem[0] = addi(5'd0, 5'd0, 12'd7);
        mem[1] = addi(5'd1, 5'd0, 12'd7);
        mem[2] = ECALL;
        start(1'b0); run_halt(100, ok);
        rd_dbg(5'd0, v);
        n_tests++; if (!ok || v !== 32'd0) begin n_fail++; $display("FAIL x0_write got %h want 0", v); end
        rd_dbg(5'd1, v);
        n_tests++; if (v !== 32'd7) begin n_fail++; $display("FAIL x1_write got %h want 7", v); end
    endtask

    task automatic test_reset_mid;
        bit ok; logic [31:0] v;
        load_alu(); start(1'b0);
        for (int i = 0; i < 50 && ret_n < 2; i++) @(negedge clk);
        #1 force_stall = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (mem_req && !mem_we && !mem_ready) begin ok = 1'b1; break; end
        end
        n_tests++; if (!ok) begin n_fail++; $display("FAIL stalled_fetch got req=%b ready=%b want 1/0", mem_req, mem_ready); end
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0; #1;
        n_tests++; if (mem_req !== 1'b0 || pc !== 32'h0) begin n_fail++; $display("FAIL midreset got req=%b pc=%h want 0/0", mem_req, pc); end
        rd_dbg(5'd1, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL midreset_reg got %h want 0", v); end
        @(negedge clk); #1 force_stall = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        run_halt(200, ok);
        rd_dbg(5'd3, v);
        n_tests++; if (!ok || v !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL rerun got %h want fffffff8", v); end
    endtask

    initial begin
        #1 reset_n = 1'b0;
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_stall();
        test_trap();
        test_illegal();
        test_x0();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
